mmu_trans_arbiter: RTL and testbench

- Shares one address-translation resource between two requesters: instruction fetch (IF) and load/store (MEM).
- Sequences each translation: direct (DA) mode, direct-mapped window (DMW0/DMW1) fast path, or a TLB lookup over a request/response handshake.
- Returns a physical address plus an exception code per request.
- Sits between the IF/MEM pipeline stages and the TLB, and sources the physical tag/index/offset consumed by the caches.

---
 rtl/mmu_pkg.sv | 44 ++++
 rtl/mmu_trans_arbiter_dmw_match.sv | 28 ++
 rtl/mmu_trans_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mmu_trans_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared types and field constants for the MMU translation arbiter.
package mmu_pkg;

    typedef enum logic [1:0] {
        EXC_NONE = 2'd0,
        EXC_TLBR = 2'd1,
        EXC_PIX  = 2'd2,
        EXC_PME  = 2'd3
    } exc_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TLB_REQ  = 3'd1,
        ST_TLB_WAIT = 3'd2,
        ST_RESP     = 3'd3,
        ST_DRAIN    = 3'd4
    } state_e;

    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // Direct-mapped window CSR fields
    localparam int DMW_VSEG_HI = 31;
    localparam int DMW_VSEG_LO = 29;
    localparam int DMW_PSEG_HI = 27;
    localparam int DMW_PSEG_LO = 25;
    localparam int DMW_PLV0    = 0;
    localparam int DMW_PLV3    = 3;

    // Exception priority for a TLB lookup result: miss, then invalid, then dirty-on-store.
    function automatic exc_e tlb_exc(input logic hit, input logic v,
                                     input logic d, input logic store);
        if (!hit)
            return EXC_TLBR;
        if (!v)
            return EXC_PIX;
        if (store && !d)
            return EXC_PME;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/mmu_trans_arbiter_dmw_match.sv
// Single direct-mapped window comparator: segment match gated by the PLV enable bit.
module mmu_dmw_match
    import mmu_pkg::*;
(
    input  logic [31:0] dmw_i,
    input  logic [2:0]  vseg_i,
    input  logic [1:0]  plv_i,
    output logic        hit_o,
    output logic [2:0]  pseg_o
);

    logic plv_en;
    logic unused_dmw;

    // Only PLV0 and PLV3 have enable bits; PLV1/2 can never use a window.
    always_comb begin
        plv_en = 1'b0;
        if (plv_i == 2'd0)
            plv_en = dmw_i[DMW_PLV0];
        else if (plv_i == 2'd3)
            plv_en = dmw_i[DMW_PLV3];
    end

    assign hit_o      = plv_en && (dmw_i[DMW_VSEG_HI:DMW_VSEG_LO] == vseg_i);
    assign pseg_o     = dmw_i[DMW_PSEG_HI:DMW_PSEG_LO];
    assign unused_dmw = ^{dmw_i[28], dmw_i[24:4], dmw_i[2:1]};

endmodule

// File: rtl/mmu_trans_arbiter.sv
// Arbitrates IF and MEM translation requests onto one translation engine
// (direct, DMW window, or TLB handshake) and returns paddr + exception.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | arbitrate and accept one request; direct/DMW resolve here
// TLB_REQ  | tlb_req_valid held with stable vpn until tlb_req_ready
// TLB_WAIT | waiting for the TLB response
// RESP     | one-cycle resp_valid pulse to the owning requester
// DRAIN    | flushed while waiting; swallow the late TLB response
module mmu_trans_arbiter
    import mmu_pkg::*;
#(
    parameter  int STARVE_LIMIT = 4,
    localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,

    input  logic        if_req_valid,
    input  logic [31:0] if_req_vaddr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_paddr,
    output logic [1:0]  if_resp_exc,

    input  logic        mem_req_valid,
    input  logic [31:0] mem_req_vaddr,
    input  logic        mem_req_store,
    output logic        mem_req_ready,
    output logic        mem_resp_valid,
    output logic [31:0] mem_resp_paddr,
    output logic [1:0]  mem_resp_exc,

    output logic        tlb_req_valid,
    output logic [18:0] tlb_req_vpn,
    input  logic        tlb_req_ready,
    input  logic        tlb_resp_valid,
    input  logic        tlb_resp_hit,
    input  logic        tlb_resp_v,
    input  logic        tlb_resp_d,
    input  logic [19:0] tlb_resp_ppn,

    input  logic        csr_crmd_da,
    input  logic        csr_crmd_pg,
    input  logic [1:0]  csr_crmd_plv,
    input  logic [31:0] csr_dmw0,
    input  logic [31:0] csr_dmw1
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       vaddr_q, vaddr_d;
    req_id_e           owner_q, owner_d;
    logic              store_q, store_d;
    logic [31:0]       paddr_q, paddr_d;
    exc_e              exc_q, exc_d;

    logic              arb_en, starved, if_grant, mem_grant, any_grant;
    logic [31:0]       acc_vaddr;
    logic              paged;
    logic              dmw0_hit, dmw1_hit;
    logic [2:0]        dmw0_pseg, dmw1_pseg;
    logic              resp_fire;
    logic              unused_vaddr;

    assign arb_en    = (state_q == ST_IDLE) && !flush;
    assign starved   = (cnt_q == CNT_W'(STARVE_LIMIT));
    assign if_grant  = arb_en && if_req_valid && (starved || !mem_req_valid);
    assign mem_grant = arb_en && mem_req_valid && !if_grant;
    assign any_grant = if_grant || mem_grant;
    assign acc_vaddr = mem_grant ? mem_req_vaddr : if_req_vaddr;
    // Anything other than da=0/pg=1 translates directly.
    assign paged     = !csr_crmd_da && csr_crmd_pg;

    mmu_dmw_match u_dmw0 (
        .dmw_i  (csr_dmw0),
        .vseg_i (acc_vaddr[31:29]),
        .plv_i  (csr_crmd_plv),
        .hit_o  (dmw0_hit),
        .pseg_o (dmw0_pseg)
    );

    mmu_dmw_match u_dmw1 (
        .dmw_i  (csr_dmw1),
        .vseg_i (acc_vaddr[31:29]),
        .plv_i  (csr_crmd_plv),
        .hit_o  (dmw1_hit),
        .pseg_o (dmw1_pseg)
    );

    // Next-state logic: starvation counter, accept-time mode decision, TLB sequencing.
    // The mode/PLV/DMW choice is fully resolved in the accept cycle, so later CSR
    // writes cannot reach an in-flight translation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vaddr_d = vaddr_q;
        owner_d = owner_q;
        store_d = store_q;
        paddr_d = paddr_q;
        exc_d   = exc_q;

        if (!if_req_valid || if_grant)
            cnt_d = '0;
        else if (mem_grant && !starved)
            cnt_d = cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (any_grant) begin
                    vaddr_d = acc_vaddr;
                    owner_d = mem_grant ? REQ_MEM : REQ_IF;
                    store_d = mem_grant && mem_req_store;
                    exc_d   = EXC_NONE;
                    if (!paged) begin
                        paddr_d = acc_vaddr;
                        state_d = ST_RESP;
                    end else if (dmw0_hit) begin
                        paddr_d = {dmw0_pseg, acc_vaddr[28:0]};
                        state_d = ST_RESP;
                    end else if (dmw1_hit) begin
                        paddr_d = {dmw1_pseg, acc_vaddr[28:0]};
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_TLB_REQ;
                    end
                end
            end
            ST_TLB_REQ: begin
                if (flush)
                    state_d = ST_IDLE;
                else if (tlb_req_ready)
                    state_d = ST_TLB_WAIT;
            end
            ST_TLB_WAIT: begin
                if (tlb_resp_valid) begin
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        exc_d   = tlb_exc(tlb_resp_hit, tlb_resp_v, tlb_resp_d, store_q);
                        paddr_d = (exc_d == EXC_NONE) ? {tlb_resp_ppn, vaddr_q[11:0]} : 32'd0;
                        state_d = ST_RESP;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (tlb_resp_valid)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            vaddr_q <= '0;
            owner_q <= REQ_IF;
            store_q <= 1'b0;
            paddr_q <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vaddr_q <= vaddr_d;
            owner_q <= owner_d;
            store_q <= store_d;
            paddr_q <= paddr_d;
            exc_q   <= exc_d;
        end
    end

    assign resp_fire      = (state_q == ST_RESP) && !flush;
    assign if_req_ready   = if_grant;
    assign mem_req_ready  = mem_grant;
    assign if_resp_valid  = resp_fire && (owner_q == REQ_IF);
    assign mem_resp_valid = resp_fire && (owner_q == REQ_MEM);
    assign if_resp_paddr  = paddr_q;
    assign mem_resp_paddr = paddr_q;
    assign if_resp_exc    = exc_q;
    assign mem_resp_exc   = exc_q;
    assign tlb_req_valid  = (state_q == ST_TLB_REQ);
    assign tlb_req_vpn    = vaddr_q[31:13];
    assign unused_vaddr   = vaddr_q[12];

endmodule

// File: tb/tb_mmu_trans_arbiter.sv
// Scoreboard bench for mmu_trans_arbiter: directed cases plus randomized
// single-request traffic, checked against a behavioural translation model.
module tb_mmu_trans_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_vaddr = '0;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_paddr;
    logic [1:0]  if_resp_exc;
    logic        mem_req_valid = 1'b0;
    logic [31:0] mem_req_vaddr = '0;
    logic        mem_req_store = 1'b0;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_paddr;
    logic [1:0]  mem_resp_exc;
    logic        tlb_req_valid;
    logic [18:0] tlb_req_vpn;
    logic        tlb_req_ready = 1'b0;
    logic        tlb_resp_valid = 1'b0;
    logic        tlb_resp_hit = 1'b0;
    logic        tlb_resp_v = 1'b0;
    logic        tlb_resp_d = 1'b0;
    logic [19:0] tlb_resp_ppn = '0;
    logic        csr_crmd_da = 1'b1;
    logic        csr_crmd_pg = 1'b0;
    logic [1:0]  csr_crmd_plv = 2'd0;
    logic [31:0] csr_dmw0 = '0;
    logic [31:0] csr_dmw1 = '0;

    int tests = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit          port;   // 0 = IF, 1 = MEM
        logic [31:0] pa;
        logic [1:0]  ex;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    mmu_trans_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .if_req_valid   (if_req_valid),
        .if_req_vaddr   (if_req_vaddr),
        .if_req_ready   (if_req_ready),
        .if_resp_valid  (if_resp_valid),
        .if_resp_paddr  (if_resp_paddr),
        .if_resp_exc    (if_resp_exc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_vaddr  (mem_req_vaddr),
        .mem_req_store  (mem_req_store),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_paddr (mem_resp_paddr),
        .mem_resp_exc   (mem_resp_exc),
        .tlb_req_valid  (tlb_req_valid),
        .tlb_req_vpn    (tlb_req_vpn),
        .tlb_req_ready  (tlb_req_ready),
        .tlb_resp_valid (tlb_resp_valid),
        .tlb_resp_hit   (tlb_resp_hit),
        .tlb_resp_v     (tlb_resp_v),
        .tlb_resp_d     (tlb_resp_d),
        .tlb_resp_ppn   (tlb_resp_ppn),
        .csr_crmd_da    (csr_crmd_da),
        .csr_crmd_pg    (csr_crmd_pg),
        .csr_crmd_plv   (csr_crmd_plv),
        .csr_dmw0       (csr_dmw0),
        .csr_dmw1       (csr_dmw1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit win_hit(input logic [31:0] w, input logic [31:0] va, input int plv);
        bit en;
        en = (plv == 0 && w[0]) || (plv == 3 && w[3]);
        return en && ((w >> 29) == (va >> 29));
    endfunction

    // Reference translation from the rules, using the CSR values live at accept.
    function automatic void model(input logic [31:0] va, input bit st, input bit hit,
                                  input bit v, input bit d, input logic [19:0] ppn,
                                  output logic [31:0] pa, output logic [1:0] ex,
                                  output bit use_tlb);
        bit paged;
        int plv;
        paged = (csr_crmd_da == 1'b0) && (csr_crmd_pg == 1'b1);
        plv = int'(csr_crmd_plv);
        use_tlb = 0;
        ex = 2'd0;
        pa = va;
        if (paged) begin
            if (win_hit(csr_dmw0, va, plv))
                pa = (((csr_dmw0 >> 25) & 32'd7) << 29) | (va & 32'h1FFF_FFFF);
            else if (win_hit(csr_dmw1, va, plv))
                pa = (((csr_dmw1 >> 25) & 32'd7) << 29) | (va & 32'h1FFF_FFFF);
            else begin
                use_tlb = 1;
                if (!hit)          begin ex = 2'd1; pa = 32'd0; end
                else if (!v)       begin ex = 2'd2; pa = 32'd0; end
                else if (st && !d) begin ex = 2'd3; pa = 32'd0; end
                else pa = ({12'd0, ppn} << 12) + (va % 32'd4096);
            end
        end
    endfunction

    // Response monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (if_resp_valid || mem_resp_valid)) begin
            if (sb.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_resp: if_v=%0b mem_v=%0b, nothing outstanding (cycle %0d)",
                         if_resp_valid, mem_resp_valid, cyc);
            end else begin
                m_e = sb.pop_front();
                chk("resp_single", 64'(if_resp_valid && mem_resp_valid), 64'd0);
                chk("resp_port", 64'(mem_resp_valid), 64'(m_e.port));
                chk("resp_paddr", 64'(m_e.port ? mem_resp_paddr : if_resp_paddr), 64'(m_e.pa));
                chk("resp_exc", 64'(m_e.port ? mem_resp_exc : if_resp_exc), 64'(m_e.ex));
                chk("resp_latency", 64'(cyc - m_e.acc), 64'(m_e.lat));
            end
        end
    end

    task automatic scramble_csr();
        csr_crmd_da  = 1'($urandom);
        csr_crmd_pg  = 1'($urandom);
        csr_crmd_plv = 2'($urandom);
        csr_dmw0     = $urandom;
        csr_dmw1     = $urandom;
    endtask

    // One request from start to finish, acting as the TLB when the model says so.
    task automatic do_txn(input bit port, input logic [31:0] va, input bit st,
                          input bit hit, input bit v, input bit d, input logic [19:0] ppn,
                          input int r0, input int r1, input bit scramble);
        bit got;
        int n;
        exp_t e;
        bit use_tlb;
        logic [31:0] pa;
        logic [1:0] ex;
        @(posedge clk); #1;
        if (port) begin
            mem_req_valid = 1'b1; mem_req_vaddr = va; mem_req_store = st;
        end else begin
            if_req_valid = 1'b1; if_req_vaddr = va;
        end
        got = 0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if ((port ? mem_req_ready : if_req_ready) === 1'b1) got = 1;
            else begin @(posedge clk); #1; n++; end
        end
        if (!got) begin
            tests++;
            errors++;
            $display("FAIL accept_timeout: port %0d not granted in 20 cycles", port);
            if_req_valid = 1'b0;
            mem_req_valid = 1'b0;
            return;
        end
        chk("ready_exclusive", 64'(port ? if_req_ready : mem_req_ready), 64'd0);
        model(va, st, hit, v, d, ppn, pa, ex, use_tlb);
        e.port = port;
        e.pa = pa;
        e.ex = ex;
        e.acc = cyc;
        e.lat = use_tlb ? 3 + r0 + r1 : 1;
        sb.push_back(e);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        mem_req_valid = 1'b0;
        if (scramble) scramble_csr();
        if (use_tlb) begin
            tlb_req_ready = 1'b0;
            repeat (r0) begin @(posedge clk); #1; end
            tlb_req_ready = 1'b1;
            @(negedge clk);
            chk("tlb_req_valid", 64'(tlb_req_valid), 64'd1);
            chk("tlb_req_vpn", 64'(tlb_req_vpn), 64'(va >> 13));
            @(posedge clk); #1;
            tlb_req_ready = 1'b0;
            repeat (r1) begin @(posedge clk); #1; end
            tlb_resp_valid = 1'b1;
            tlb_resp_hit = hit; tlb_resp_v = v; tlb_resp_d = d; tlb_resp_ppn = ppn;
            @(posedge clk); #1;
            tlb_resp_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va;
        int pick;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_if_ready", 64'(if_req_ready), 64'd0);
        chk("rst_mem_ready", 64'(mem_req_ready), 64'd0);
        chk("rst_resp_valids", 64'({if_resp_valid, mem_resp_valid}), 64'd0);
        chk("rst_tlb_req_valid", 64'(tlb_req_valid), 64'd0);
        chk("rst_paddr", 64'({if_resp_paddr, mem_resp_paddr}), 64'd0);
        chk("rst_exc", 64'({if_resp_exc, mem_resp_exc}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Direct mode IF request
        csr_crmd_da = 1'b1; csr_crmd_pg = 1'b0;
        do_txn(0, 32'h1C00_0100, 0, 0, 0, 0, 20'h0, 0, 0, 0);

        // DMW0 hit at PLV0, then same address at PLV3 falls to the TLB
        csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_crmd_plv = 2'd0;
        csr_dmw0 = 32'hA000_0001; csr_dmw1 = 32'h0;
        do_txn(1, 32'hA123_4568, 0, 0, 0, 0, 20'h0, 0, 0, 0);
        csr_crmd_plv = 2'd3;
        do_txn(1, 32'hA123_4568, 0, 1, 1, 1, 20'hABCDE, 0, 0, 0);

        // TLB exceptions and a clean 3-cycle hit
        do_txn(1, 32'h0040_2ABC, 1, 1, 1, 0, 20'h12345, 0, 0, 0);
        do_txn(1, 32'h0040_2ABC, 1, 1, 1, 1, 20'h12345, 0, 0, 0);
        do_txn(1, 32'h0040_2ABC, 0, 0, 1, 1, 20'h12345, 1, 2, 0);
        do_txn(0, 32'h0040_2ABC, 0, 1, 0, 1, 20'h12345, 2, 1, 0);

        // DMW1 used when DMW0 misses
        csr_dmw1 = 32'h2800_0008;
        do_txn(0, 32'h3765_4321, 0, 0, 0, 0, 20'h0, 0, 0, 0);

        // Contention: four MEM grants then one IF grant, repeating
        csr_crmd_da = 1'b1; csr_crmd_pg = 1'b0;
        @(posedge clk); #1;
        if_req_valid = 1'b1; mem_req_valid = 1'b1; mem_req_store = 1'b0;
        if_req_vaddr = $urandom; mem_req_vaddr = $urandom;
        for (int k = 0; k < 10; k++) begin
            bit got;
            int n;
            bit exp_mem;
            exp_t e;
            exp_mem = (k % 5) != 4;
            got = 0;
            n = 0;
            while (!got && n < 10) begin
                @(negedge clk);
                if (if_req_ready || mem_req_ready) got = 1;
                else begin @(posedge clk); #1; n++; end
            end
            if (!got) begin
                tests++;
                errors++;
                $display("FAIL arb_timeout: no grant at step %0d", k);
                break;
            end
            chk("arb_one_ready", 64'(if_req_ready && mem_req_ready), 64'd0);
            chk("arb_winner_is_mem", 64'(mem_req_ready), 64'(exp_mem));
            e.port = exp_mem;
            e.pa = exp_mem ? mem_req_vaddr : if_req_vaddr;
            e.ex = 2'd0;
            e.acc = cyc;
            e.lat = 1;
            sb.push_back(e);
            @(posedge clk); #1;
            if (exp_mem) mem_req_vaddr = $urandom;
            else if_req_vaddr = $urandom;
        end
        if_req_valid = 1'b0; mem_req_valid = 1'b0;

        // Flush in IDLE with both requesters valid: no grant
        @(posedge clk); #1;
        if_req_valid = 1'b1; mem_req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("flush_idle_if_ready", 64'(if_req_ready), 64'd0);
        chk("flush_idle_mem_ready", 64'(mem_req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; if_req_valid = 1'b0; mem_req_valid = 1'b0;

        // Flush in RESP suppresses the pulse
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_req_vaddr = 32'h1234_5678;
        @(negedge clk);
        chk("flush_resp_accept", 64'(if_req_ready), 64'd1);
        @(posedge clk); #1;
        if_req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_resp_suppressed", 64'(if_resp_valid), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;

        // Flush in TLB_REQ drops the request
        csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_crmd_plv = 2'd1;
        mem_req_valid = 1'b1; mem_req_vaddr = 32'h0001_2000; mem_req_store = 1'b0;
        @(negedge clk);
        chk("flush_tlbreq_accept", 64'(mem_req_ready), 64'd1);
        @(posedge clk); #1;
        mem_req_valid = 1'b0; tlb_req_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_tlbreq_dropped", 64'(tlb_req_valid), 64'd0);

        // Flush in TLB_WAIT: response arrives 5 cycles later and is drained
        @(posedge clk); #1;
        mem_req_valid = 1'b1; mem_req_vaddr = 32'h0005_5000;
        @(negedge clk);
        chk("drain_accept", 64'(mem_req_ready), 64'd1);
        @(posedge clk); #1;
        mem_req_valid = 1'b0; tlb_req_ready = 1'b1;
        @(posedge clk); #1;
        tlb_req_ready = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        csr_crmd_da = 1'b1;
        if_req_valid = 1'b1; if_req_vaddr = 32'h0BAD_F00D;
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                tlb_resp_valid = 1'b1; tlb_resp_hit = 1'b1; tlb_resp_v = 1'b1;
                tlb_resp_d = 1'b1; tlb_resp_ppn = 20'h77777;
            end
            @(negedge clk);
            chk("drain_hold_grant", 64'(if_req_ready), 64'd0);
            chk("drain_no_resp", 64'(if_resp_valid || mem_resp_valid), 64'd0);
            @(posedge clk); #1;
        end
        tlb_resp_valid = 1'b0;
        @(negedge clk);
        chk("drain_release_grant", 64'(if_req_ready), 64'd1);
        begin
            exp_t e;
            e.port = 0; e.pa = 32'h0BAD_F00D; e.ex = 2'd0; e.acc = cyc; e.lat = 1;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0;

        // Randomized single-requester traffic with CSR churn after accept
        for (int t = 0; t < 60; t++) begin
            bit port;
            bit st;
            va = $urandom;
            csr_crmd_da = ($urandom_range(0, 3) == 0);
            csr_crmd_pg = ($urandom_range(0, 4) != 0);
            pick = $urandom_range(0, 5);
            csr_crmd_plv = (pick < 2) ? 2'd0 : (pick < 4) ? 2'd3 : 2'(pick - 3);
            csr_dmw0 = $urandom;
            if ($urandom_range(0, 1) == 1) csr_dmw0[31:29] = va[31:29];
            csr_dmw1 = $urandom;
            if ($urandom_range(0, 1) == 1) csr_dmw1[31:29] = va[31:29];
            port = 1'($urandom_range(0, 1));
            st = port ? 1'($urandom_range(0, 1)) : 1'b0;
            do_txn(port, va, st, $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
                   1'($urandom_range(0, 1)), 20'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 3), 1);
        end

        // Asynchronous reset while in TLB_REQ
        @(posedge clk); #1;
        csr_crmd_da = 1'b0; csr_crmd_pg = 1'b1; csr_crmd_plv = 2'd2;
        mem_req_valid = 1'b1; mem_req_vaddr = 32'hCAFE_B000;
        @(negedge clk);
        chk("arst_accept", 64'(mem_req_ready), 64'd1);
        @(posedge clk); #1;
        mem_req_valid = 1'b0; tlb_req_ready = 1'b0;
        @(negedge clk);
        chk("arst_in_tlb_req", 64'(tlb_req_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_tlb_req_drop", 64'(tlb_req_valid), 64'd0);
        chk("arst_resp_valids", 64'({if_resp_valid, mem_resp_valid}), 64'd0);
        chk("arst_readies", 64'({if_req_ready, mem_req_ready}), 64'd0);
        chk("arst_paddr", 64'({if_resp_paddr, mem_resp_paddr}), 64'd0);
        chk("arst_exc", 64'({if_resp_exc, mem_resp_exc}), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        csr_crmd_da = 1'b1;
        do_txn(1, 32'h0F0F_1234, 0, 0, 0, 0, 20'h0, 0, 0, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
